// File: rtl/scan_chain_controller_pkg.sv
// Shared types and sizing for the register-file scan chain controller.
package scan_chain_controller_pkg;

  localparam int DATA_BUS_WIDTH                    = 8;
  localparam int GENERAL_REGISTERS                 = 4;
  localparam int REGISTERS_IN_BANK_WITH_SCAN_CHAIN = 8;
  localparam int SCAN_BYTE_WIDTH                   = 8;

  // The chain covers the general registers followed by the scanned bank registers.
  localparam int DEFAULT_CHAIN_BITS =
    (GENERAL_REGISTERS + REGISTERS_IN_BANK_WITH_SCAN_CHAIN) * DATA_BUS_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    EMIT
  } scan_state_e;

  typedef logic [SCAN_BYTE_WIDTH-1:0] scan_byte_t;

endpackage

// File: rtl/scan_chain_controller_if.sv
// Byte-wide host port of the scan chain controller: session start, byte streams, status.
interface scan_chain_controller_if;
  import scan_chain_controller_pkg::*;

  logic       start;
  scan_byte_t in_data;
  logic       in_valid;
  logic       in_ready;
  scan_byte_t out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  modport master (
    output start, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, busy, done
  );

  modport slave (
    input  start, in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, busy, done
  );

endinterface

// File: rtl/scan_chain_controller_shifter.sv
// Per-byte serialiser/deserialiser: presents one TX bit per shift, captures the chain tail LSB first.
module scan_byte_shifter
  import scan_chain_controller_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       load,
  input  logic       shift,
  input  scan_byte_t load_data,
  input  logic       serial_in,
  output logic       scan_in,
  output scan_byte_t rx_next,
  output logic       last_bit
);

  localparam int CNT_W = $clog2(SCAN_BYTE_WIDTH);

  logic [SCAN_BYTE_WIDTH-2:0] tx_sr;
  logic [SCAN_BYTE_WIDTH-2:0] rx_sr;
  logic [CNT_W-1:0]           bit_cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt <= '0;
      scan_in <= 1'b0;
    end else if (load) begin
      bit_cnt <= '0;
      scan_in <= load_data[0];
    end else if (shift) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
      scan_in <= tx_sr[0];
    end
  end

  // Bit 0 goes straight to scan_in on load, so only the remaining bits are held here.
  always_ff @(posedge clock) begin
    if (load) begin
      tx_sr <= load_data[SCAN_BYTE_WIDTH-1:1];
    end else if (shift) begin
      tx_sr <= tx_sr >> 1;
    end
    if (shift) begin
      rx_sr <= rx_next[SCAN_BYTE_WIDTH-1:1];
    end
  end

  assign rx_next  = {serial_in, rx_sr};
  assign last_bit = (bit_cnt == CNT_W'(SCAN_BYTE_WIDTH - 1));

endmodule

// File: rtl/scan_chain_controller.sv
// Scan chain session controller: swaps a full chain image byte by byte with the host.
module scan_chain_controller
  import scan_chain_controller_pkg::*;
#(
  parameter int CHAIN_BITS = DEFAULT_CHAIN_BITS
) (
  input  logic                    clock,
  input  logic                    reset,
  scan_chain_controller_if.slave  host,
  output logic                    test,
  output logic                    scan_in,
  input  logic                    scan_out
);

  localparam int BYTE_COUNT = CHAIN_BITS / SCAN_BYTE_WIDTH;
  localparam int BYTE_CNT_W = (BYTE_COUNT > 1) ? $clog2(BYTE_COUNT) : 1;
  localparam logic [BYTE_CNT_W-1:0] LAST_BYTE = BYTE_CNT_W'(BYTE_COUNT - 1);

  if ((CHAIN_BITS % SCAN_BYTE_WIDTH) != 0 || CHAIN_BITS <= 0) begin : g_chain_bits_check
    $error("CHAIN_BITS must be a positive multiple of the scan byte width");
  end

  scan_state_e           state;
  scan_state_e           state_next;
  logic [BYTE_CNT_W-1:0] byte_cnt;
  logic                  session_start;
  logic                  load;
  logic                  shift;
  logic                  next_byte;
  logic                  finish;
  logic                  last_bit;
  scan_byte_t            rx_next;

  scan_byte_shifter u_shifter (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .shift     (shift),
    .load_data (host.in_data),
    .serial_in (scan_out),
    .scan_in   (scan_in),
    .rx_next   (rx_next),
    .last_bit  (last_bit)
  );

  always_comb begin
    state_next    = state;
    session_start = 1'b0;
    load          = 1'b0;
    shift         = 1'b0;
    next_byte     = 1'b0;
    finish        = 1'b0;
    case (state)
      IDLE: begin
        if (host.start) begin
          session_start = 1'b1;
          state_next    = LOAD;
        end
      end
      LOAD: begin
        if (host.in_valid) begin
          load       = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift = 1'b1;
        if (last_bit) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (host.out_ready) begin
          if (byte_cnt == LAST_BYTE) begin
            finish     = 1'b1;
            state_next = IDLE;
          end else begin
            next_byte  = 1'b1;
            state_next = LOAD;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // test only rises on a byte load and falls on its eighth shift, so stalls never shift the chain.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      byte_cnt      <= '0;
      test          <= 1'b0;
      host.done     <= 1'b0;
      host.out_data <= '0;
    end else begin
      state     <= state_next;
      host.done <= finish;
      if (session_start) begin
        byte_cnt <= '0;
      end else if (next_byte) begin
        byte_cnt <= byte_cnt + BYTE_CNT_W'(1);
      end
      if (load) begin
        test <= 1'b1;
      end else if (shift && last_bit) begin
        test <= 1'b0;
      end
      if (shift && last_bit) begin
        host.out_data <= rx_next;
      end
    end
  end

  assign host.in_ready  = (state == LOAD);
  assign host.out_valid = (state == EMIT);
  assign host.busy      = (state != IDLE);

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: register-file chain model plus a position-level image predictor.
module tb_scan_chain_controller;

  localparam int CHAIN_BITS = 96;
  localparam int BYTES      = CHAIN_BITS / 8;
  localparam int TIMEOUT    = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic test;
  logic scan_in;
  logic scan_out;

  scan_chain_controller_if host ();

  scan_chain_controller #(.CHAIN_BITS(CHAIN_BITS)) dut (
    .clock    (clock),
    .reset    (reset),
    .host     (host),
    .test     (test),
    .scan_in  (scan_in),
    .scan_out (scan_out)
  );

  always #5 clock = ~clock;

  // Register file side: bit 0 is the chain tail; byte position p is bits [8p+7:8p].
  logic [CHAIN_BITS-1:0] chain = '0;
  logic                  fw_en = 1'b0;
  int                    fw_pos = 0;
  logic [7:0]            fw_val = '0;
  int test_cycles = 0;
  int busy_cycles = 0;
  int done_count  = 0;

  assign scan_out = chain[0];

  always @(posedge clock) begin
    if (test === 1'b1) chain <= {scan_in, chain[CHAIN_BITS-1:1]};
    else if (fw_en) chain[fw_pos*8 +: 8] <= fw_val;
    if (test === 1'b1) test_cycles <= test_cycles + 1;
    if (host.busy === 1'b1) busy_cycles <= busy_cycles + 1;
    if (host.done === 1'b1) done_count <= done_count + 1;
  end

  logic [CHAIN_BITS-1:0] model_img = '0;
  logic [7:0] tx_bytes [BYTES];
  logic [7:0] rx_bytes [BYTES];
  logic [7:0] exp_rx   [BYTES];

  int checks = 0;
  int failures = 0;

  bit         obs_timeout;
  int         obs_proto_bad;
  int         obs_cycles;
  int         obs_shifts;
  int         obs_dones;
  logic       obs_done_after, obs_busy_after, obs_done_next, obs_busy_next;
  logic [4:0] obs_abort_ctrl;

  function automatic int bank_pos(input int b);
    return 7 - b;
  endfunction

  function automatic int reg_pos(input int r);
    return 11 - r;
  endfunction

  task automatic fwrite(input int pos, input logic [7:0] val);
    fw_en = 1'b1; fw_pos = pos; fw_val = val;
    @(negedge clock);
    fw_en = 1'b0;
    model_img[pos*8 +: 8] = val;
  endtask

  task automatic load_known_image();
    for (int r = 0; r < 4; r++) fwrite(reg_pos(r), 8'(8'h10 + r));
    for (int b = 0; b < 8; b++) fwrite(bank_pos(b), 8'(8'h20 + b));
  endtask

  // A full session returns each position's old value and leaves the new byte there.
  task automatic predict_session();
    for (int k = 0; k < BYTES; k++) begin
      exp_rx[k] = model_img[k*8 +: 8];
      model_img[k*8 +: 8] = tx_bytes[k];
    end
  endtask

  task automatic predict_partial(input int s);
    logic [CHAIN_BITS-1:0] stream;
    for (int k = 0; k < BYTES; k++) stream[k*8 +: 8] = tx_bytes[k];
    model_img = (model_img >> s) | (stream << (CHAIN_BITS - s));
  endtask

  task automatic randomize_tx();
    for (int k = 0; k < BYTES; k++) tx_bytes[k] = 8'($urandom);
  endtask

  task automatic drive_session(input int in_stall_byte, input int in_stall,
                               input int out_stall_byte, input int out_stall,
                               input int abort_byte, input bit keep_start, input bit started);
    int c0, s0, d0, wait_n;
    logic [7:0] held;
    obs_timeout = 1'b0; obs_proto_bad = 0;
    c0 = busy_cycles; s0 = test_cycles; d0 = done_count;
    if (!started) begin
      host.start = 1'b1;
      @(negedge clock);
      host.start = keep_start;
    end
    for (int k = 0; k < BYTES; k++) begin
      if (k == in_stall_byte) begin
        repeat (in_stall) begin
          if (test !== 1'b0 || host.in_ready !== 1'b1) obs_proto_bad++;
          @(negedge clock);
        end
      end
      host.in_data = tx_bytes[k];
      host.in_valid = 1'b1;
      wait_n = 0;
      while (host.in_ready !== 1'b1 && wait_n < TIMEOUT) begin
        @(negedge clock); wait_n++;
      end
      if (wait_n >= TIMEOUT) begin
        obs_timeout = 1'b1; host.in_valid = 1'b0; return;
      end
      @(negedge clock);
      host.in_valid = 1'b0;
      if (k == abort_byte) begin
        repeat (4) @(negedge clock);
        #2 reset = 1'b1;
        #1 obs_abort_ctrl = {test, host.busy, host.in_ready, host.out_valid, host.done};
        return;
      end
      wait_n = 0;
      while (host.out_valid !== 1'b1 && wait_n < TIMEOUT) begin
        @(negedge clock); wait_n++;
      end
      if (wait_n >= TIMEOUT) begin
        obs_timeout = 1'b1; return;
      end
      if (k == out_stall_byte) begin
        held = host.out_data;
        repeat (out_stall) begin
          if (test !== 1'b0 || host.out_valid !== 1'b1 || host.out_data !== held) obs_proto_bad++;
          @(negedge clock);
        end
      end
      rx_bytes[k] = host.out_data;
      host.out_ready = 1'b1;
      @(negedge clock);
      host.out_ready = 1'b0;
      if (host.out_valid !== 1'b0) obs_proto_bad++;
    end
    obs_done_after = host.done;
    obs_busy_after = host.busy;
    @(negedge clock);
    obs_done_next = host.done;
    obs_busy_next = host.busy;
    obs_cycles = busy_cycles - c0;
    obs_shifts = test_cycles - s0;
    obs_dones  = done_count - d0;
  endtask

  task automatic test_reset();
    host.start = 1'b0; host.in_valid = 1'b0; host.in_data = '0; host.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({test, scan_in, host.in_ready, host.out_valid, host.busy, host.done} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {test, scan_in, host.in_ready, host.out_valid, host.busy, host.done});
    end
    checks++;
    if (host.out_data !== 8'h00) begin
      failures++; $display("FAIL reset_out_data got=%02h want=00", host.out_data);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (host.busy !== 1'b0 || test !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset busy=%b test=%b want=0/0", host.busy, test);
    end
  endtask

  task automatic test_round_trip();
    logic [7:0] want;
    load_known_image();
    for (int k = 0; k < BYTES; k++) tx_bytes[k] = 8'(8'hA0 + k);
    predict_session();
    drive_session(-1, 0, -1, 0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0) begin failures++; $display("FAIL rt_timeout got=1 want=0"); end
    for (int k = 0; k < BYTES; k++) begin
      want = (k < 8) ? 8'(8'h27 - k) : 8'(8'h13 - (k - 8));
      checks++;
      if (rx_bytes[k] !== want) begin
        failures++; $display("FAIL rt_out[%0d] got=%02h want=%02h", k, rx_bytes[k], want);
      end
    end
    for (int b = 0; b < 8; b++) begin
      checks++;
      if (chain[bank_pos(b)*8 +: 8] !== 8'(8'hA0 + (7 - b))) begin
        failures++; $display("FAIL rt_bank[%0d] got=%02h want=%02h", b,
                             chain[bank_pos(b)*8 +: 8], 8'(8'hA0 + (7 - b)));
      end
    end
    for (int r = 0; r < 4; r++) begin
      checks++;
      if (chain[reg_pos(r)*8 +: 8] !== 8'(8'hA0 + (11 - r))) begin
        failures++; $display("FAIL rt_reg[%0d] got=%02h want=%02h", r,
                             chain[reg_pos(r)*8 +: 8], 8'(8'hA0 + (11 - r)));
      end
    end
    checks++;
    if (obs_shifts != CHAIN_BITS) begin
      failures++; $display("FAIL rt_test_cycles got=%0d want=%0d", obs_shifts, CHAIN_BITS);
    end
    checks++;
    if (obs_cycles != 120) begin
      failures++; $display("FAIL rt_session_cycles got=%0d want=120", obs_cycles);
    end
    checks++;
    if (obs_dones != 1 || obs_done_after !== 1'b1 || obs_busy_after !== 1'b0 || obs_done_next !== 1'b0) begin
      failures++; $display("FAIL rt_done count=%0d done=%b busy=%b done_next=%b want=1/1/0/0",
                           obs_dones, obs_done_after, obs_busy_after, obs_done_next);
    end
    checks++;
    if (obs_proto_bad != 0) begin
      failures++; $display("FAIL rt_out_valid_drop got=%0d want=0", obs_proto_bad);
    end
  endtask

  task automatic test_readback();
    for (int k = 0; k < BYTES; k++) tx_bytes[k] = 8'h00;
    predict_session();
    drive_session(-1, 0, -1, 0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0) begin failures++; $display("FAIL rb_timeout got=1 want=0"); end
    for (int k = 0; k < BYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== 8'(8'hA0 + k)) begin
        failures++; $display("FAIL rb_out[%0d] got=%02h want=%02h", k, rx_bytes[k], 8'(8'hA0 + k));
      end
    end
    checks++;
    if (chain !== model_img) begin
      failures++; $display("FAIL rb_chain got=%h want=%h", chain, model_img);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] want;
    load_known_image();
    for (int k = 0; k < BYTES; k++) tx_bytes[k] = 8'(8'hA0 + k);
    predict_session();
    drive_session(3, 5, 7, 10, -1, 1'b0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0) begin failures++; $display("FAIL bp_timeout got=1 want=0"); end
    checks++;
    if (obs_proto_bad != 0) begin
      failures++; $display("FAIL bp_stall_behaviour bad_cycles=%0d want=0", obs_proto_bad);
    end
    for (int k = 0; k < BYTES; k++) begin
      want = (k < 8) ? 8'(8'h27 - k) : 8'(8'h13 - (k - 8));
      checks++;
      if (rx_bytes[k] !== want) begin
        failures++; $display("FAIL bp_out[%0d] got=%02h want=%02h", k, rx_bytes[k], want);
      end
    end
    checks++;
    if (chain !== model_img) begin
      failures++; $display("FAIL bp_chain got=%h want=%h", chain, model_img);
    end
    checks++;
    if (obs_cycles != 135 || obs_shifts != CHAIN_BITS) begin
      failures++; $display("FAIL bp_cycles session=%0d test=%0d want=135/%0d",
                           obs_cycles, obs_shifts, CHAIN_BITS);
    end
  endtask

  task automatic test_reset_mid_shift();
    int s0, d0, shifted;
    randomize_tx();
    s0 = test_cycles; d0 = done_count;
    drive_session(-1, 0, -1, 0, 2, 1'b0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_abort_ctrl !== 5'b0) begin
      failures++; $display("FAIL abort_async {test,busy,in_ready,out_valid,done}=%b want=00000",
                           obs_abort_ctrl);
    end
    repeat (3) @(negedge clock);
    shifted = test_cycles - s0;
    checks++;
    if (shifted != 20) begin
      failures++; $display("FAIL abort_shift_count got=%0d want=20", shifted);
    end
    predict_partial(20);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checks++;
    if (host.busy !== 1'b0 || host.in_ready !== 1'b0 || done_count != d0) begin
      failures++; $display("FAIL abort_idle busy=%b in_ready=%b dones=%0d want=0/0/0",
                           host.busy, host.in_ready, done_count - d0);
    end
    randomize_tx();
    predict_session();
    drive_session(-1, 0, -1, 0, -1, 1'b0, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_dones != 1) begin
      failures++; $display("FAIL abort_recover timeout=%b dones=%0d want=0/1", obs_timeout, obs_dones);
    end
    for (int k = 0; k < BYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_rx[k]) begin
        failures++; $display("FAIL abort_out[%0d] got=%02h want=%02h", k, rx_bytes[k], exp_rx[k]);
      end
    end
    checks++;
    if (chain !== model_img) begin
      failures++; $display("FAIL abort_chain got=%h want=%h", chain, model_img);
    end
  endtask

  task automatic test_protocol_edges();
    int s0;
    s0 = test_cycles;
    host.in_valid = 1'b1; host.in_data = 8'h5A;
    repeat (3) begin
      checks++;
      if (host.in_ready !== 1'b0) begin
        failures++; $display("FAIL idle_in_ready got=%b want=0", host.in_ready);
      end
      @(negedge clock);
    end
    checks++;
    if (test_cycles != s0 || host.busy !== 1'b0) begin
      failures++; $display("FAIL idle_no_consume shifts=%0d busy=%b want=0/0", test_cycles - s0, host.busy);
    end
    host.in_valid = 1'b0;

    randomize_tx();
    predict_session();
    drive_session(-1, 0, -1, 0, -1, 1'b1, 1'b0);
    checks++;
    if (obs_timeout !== 1'b0 || obs_cycles != 120 || obs_dones != 1) begin
      failures++; $display("FAIL hold_start_single timeout=%b cycles=%0d dones=%0d want=0/120/1",
                           obs_timeout, obs_cycles, obs_dones);
    end
    checks++;
    if (obs_done_after !== 1'b1 || obs_busy_after !== 1'b0 || obs_busy_next !== 1'b1 || obs_done_next !== 1'b0) begin
      failures++; $display("FAIL hold_start_restart done=%b busy=%b next_busy=%b next_done=%b want=1/0/1/0",
                           obs_done_after, obs_busy_after, obs_busy_next, obs_done_next);
    end
    for (int k = 0; k < BYTES; k++) begin
      checks++;
      if (rx_bytes[k] !== exp_rx[k]) begin
        failures++; $display("FAIL hold_out[%0d] got=%02h want=%02h", k, rx_bytes[k], exp_rx[k]);
      end
    end
    host.start = 1'b0;
    randomize_tx();
    predict_session();
    drive_session(-1, 0, -1, 0, -1, 1'b0, 1'b1);
    checks++;
    if (obs_timeout !== 1'b0 || obs_dones != 1 || obs_busy_next !== 1'b0) begin
      failures++; $display("FAIL restarted_session timeout=%b dones=%0d next_busy=%b want=0/1/0",
                           obs_timeout, obs_dones, obs_busy_next);
    end
    checks++;
    if (chain !== model_img) begin
      failures++; $display("FAIL restarted_chain got=%h want=%h", chain, model_img);
    end
  endtask

  task automatic test_random_sessions();
    int isb, isl, osb, osl;
    for (int n = 0; n < 3; n++) begin
      randomize_tx();
      isb = $urandom_range(0, BYTES - 1); isl = $urandom_range(0, 6);
      osb = $urandom_range(0, BYTES - 1); osl = $urandom_range(0, 6);
      predict_session();
      drive_session(isb, isl, osb, osl, -1, 1'b0, 1'b0);
      checks++;
      if (obs_timeout !== 1'b0 || obs_proto_bad != 0) begin
        failures++; $display("FAIL rnd%0d_protocol timeout=%b bad=%0d want=0/0", n, obs_timeout, obs_proto_bad);
      end
      for (int k = 0; k < BYTES; k++) begin
        checks++;
        if (rx_bytes[k] !== exp_rx[k]) begin
          failures++; $display("FAIL rnd%0d_out[%0d] got=%02h want=%02h", n, k, rx_bytes[k], exp_rx[k]);
        end
      end
      checks++;
      if (obs_cycles != 120 + isl + osl || obs_shifts != CHAIN_BITS) begin
        failures++; $display("FAIL rnd%0d_cycles session=%0d test=%0d want=%0d/%0d",
                             n, obs_cycles, obs_shifts, 120 + isl + osl, CHAIN_BITS);
      end
      checks++;
      if (chain !== model_img) begin
        failures++; $display("FAIL rnd%0d_chain got=%h want=%h", n, chain, model_img);
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_trip();
    test_readback();
    test_backpressure();
    test_reset_mid_shift();
    test_protocol_edges();
    test_random_sessions();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/scan_chain_controller.md
Name: scan_chain_controller

Overview:
- Drives the register-file scan chain (`test`/`scan_in`/`scan_out`) from a byte-wide host interface.
- Each session shifts a full chain image in while capturing the previous image out, one byte at a time. Input and output bytes use valid/ready handshakes.
- Sits between the debug/test host port and the register file. It is the writer/reader for the chain that the register file exposes.

Parameters:
- CHAIN_BITS, 96, total scan-chain length in bits: (4 general registers + 8 scanned bank registers) x 8. Must be a multiple of 8; elaboration error otherwise.
- BYTE_COUNT, CHAIN_BITS/8, derived localparam (12): bytes per session.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  pulse in IDLE begins a session; ignored when busy
- in_data  input  8  next chain byte to shift in
- in_valid  input  1  in_data valid
- in_ready  output  1  controller accepts in_data this cycle
- out_data  output  8  captured chain byte
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts out_data
- test  output  1  scan-enable to register file, registered
- scan_in  output  1  serial data into chain, registered
- scan_out  input  1  serial data from chain tail
- busy  output  1  high from start acceptance until session end; system gates functional register writes with it
- done  output  1  one-cycle pulse after final byte is handed off

Behaviour:
- Reset, asynchronous: state=IDLE. test, scan_in, in_ready, out_valid, busy, done, out_data and all counters are 0. Reset mid-session abandons it immediately. test falls asynchronously and no further shift occurs; chain contents are left partially shifted.
- States (enum `scan_state_e`): IDLE, LOAD, SHIFT, EMIT.
- IDLE:
  - start=1 -> LOAD, busy<=1, byte_cnt<=0.
- LOAD:
  - in_ready=1.
  - On in_valid&&in_ready: tx_sr<=in_data, bit_cnt<=0, test<=1, scan_in<=in_data[0] -> SHIFT.
  - test=0 while waiting; no shifts occur.
- SHIFT, exactly 8 cycles with test=1:
  - Each edge: rx_sr<={scan_out, rx_sr[7:1]} and tx_sr>>=1.
  - scan_in presents the next tx bit, so the chain shifts with the bit in flight.
  - scan_out is sampled on the same edge at which the chain shifts, i.e. its pre-shift value.
  - At bit_cnt==7: test<=0, out_data<=captured byte -> EMIT.
- Bit order: LSB first in both directions.
- Byte order:
  - Captured byte k is chain position k from the tail: bank[7], bank[6], ..., bank[0], reg[3], ..., reg[0].
  - Input byte k lands in the same position. A session writes position k with in byte k and returns its old value as out byte k.
- EMIT:
  - out_valid=1, out_data stable until the handshake.
  - On out_ready: if byte_cnt==BYTE_COUNT-1 -> IDLE, busy<=0, done<=1 next cycle.
  - Otherwise byte_cnt++ -> LOAD.
  - out_valid drops the cycle after the handshake.
- Pauses (LOAD wait, EMIT backpressure) only occur at byte boundaries. test is never high for other than exactly CHAIN_BITS cycles per session.
- Minimum session: 12 x (1 LOAD + 8 SHIFT + 1 EMIT) = 120 cycles.
- start during busy is ignored; no queuing.
- done never coincides with busy=1. A start in the same cycle as done is accepted.

Decomposition:
- Shared package holds:
  - `scan_state_e` {IDLE, LOAD, SHIFT, EMIT}.
  - SCAN_BYTE_WIDTH=8.
  - Default CHAIN_BITS, computed from register-file counts: (4 + REGISTERS_IN_BANK_WITH_SCAN_CHAIN) x DATA_BUS_WIDTH.
- One sub-module, `scan_byte_shifter`: 8-bit parallel-load TX shift register, RX capture register, 3-bit bit counter, `last_bit` flag.
- FSM, byte counter and handshakes stay in the top.

Test Plan:
- Round trip:
  - Stimulus: functionally write reg[0..3]=0x10..0x13 and bank[0..7]=0x20..0x27; start; feed in bytes 0xA0..0xAB with out_ready=1.
  - Response: out bytes 0x27..0x20 then 0x13..0x10. Afterwards bank[7]=0xA0, ..., reg[0]=0xAB. test high exactly 96 cycles. done pulses once; session takes 120 cycles.
- Second session feeding 0x00 x12: out bytes 0xA0..0xAB, i.e. readback of the first session.
- Backpressure:
  - Stimulus: in_valid withheld 5 cycles before byte 3; out_ready held low 10 cycles on byte 7.
  - Response: test=0 throughout both stalls; out_data stable while stalled; chain result identical to the round-trip test; session takes 135 cycles.
- Reset mid-shift: assert reset during bit 4 of byte 2 -> test=0, busy=0 immediately, no done, FSM in IDLE. A new session then completes correctly.
- Protocol edges:
  - start held high for the whole session -> exactly one session, then a new one starts the cycle after done.
  - in_valid high in IDLE -> in_ready=0, byte not consumed.
